// File: rtl/exp_scale_pipe.sv
// exp_scale_pipe: 3-stage fixed-point e^x (integer LUT x fractional LUT, rounded, saturated).
// Optional saturation counter enabled by EXP_SCALE_STATS_EN.
module exp_scale_pipe #(
  parameter int IN_W     = 8,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_exp,
  output logic              out_sat,
  output logic [15:0]       sat_cnt
);
  localparam int IW = IN_W - IN_FRAC;
  localparam int FW = OUT_FRAC + 2;
  localparam int PW = OUT_W + OUT_FRAC + 2;
  localparam logic [OUT_W-1:0] MAXV = {OUT_W{1'b1}};
  // LUT entry i holds the integer part k = signed(i), so in_x's top bits index it directly
  function automatic real int_real(input int i);
    int kk;
    kk = (i >= 2**(IW-1)) ? i - 2**IW : i;
    return $exp(real'(kk)) * (2.0 ** OUT_FRAC);
  endfunction
  logic [OUT_W-1:0] int_lut [2**IW];
  logic [2**IW-1:0] ovf_lut;
  logic [FW-1:0]    frc_lut [2**IN_FRAC];
  for (genvar i = 0; i < 2**IW; i++) begin : g_int
    localparam real E = int_real(i);
    localparam bit  O = E >= real'(2**OUT_W - 1);
    assign int_lut[i] = O ? MAXV : OUT_W'($rtoi(E + 0.5));
    assign ovf_lut[i] = O;
  end
  for (genvar i = 0; i < 2**IN_FRAC; i++) begin : g_frc
    localparam real F = $exp(real'(i) / real'(2**IN_FRAC)) * (2.0 ** OUT_FRAC);
    assign frc_lut[i] = FW'($rtoi(F + 0.5));
  end
  logic             adv, v1, v2, o1, o2;
  logic [OUT_W-1:0] a1;
  logic [FW-1:0]    b1;
  logic [PW-1:0]    p2;
  logic [PW:0]      sum;
  logic             sat3;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign sum      = {1'b0, p2} + (PW+1)'(2**(OUT_FRAC-1));
  assign sat3     = o2 | (|sum[PW:OUT_W+OUT_FRAC]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      o1        <= 1'b0;
      o2        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      a1        <= int_lut[in_x[IN_W-1:IN_FRAC]];
      b1        <= frc_lut[in_x[IN_FRAC-1:0]];
      o1        <= ovf_lut[in_x[IN_W-1:IN_FRAC]];
      v2        <= v1;
      p2        <= PW'(a1) * PW'(b1);
      o2        <= o1;
      out_valid <= v2;
      out_exp   <= sat3 ? MAXV : sum[OUT_W+OUT_FRAC-1:OUT_FRAC];
      out_sat   <= sat3;
    end
  end
`ifdef EXP_SCALE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`else
  assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_exp_scale_pipe.sv
// tb_exp_scale_pipe: scoreboard bench for exp_scale_pipe with a real-arithmetic e^x model.
module tb_exp_scale_pipe;
  logic        clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [7:0]  in_x;
  logic [11:0] out_exp;
  logic [15:0] sat_cnt;
  exp_scale_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_sat(out_sat),
    .sat_cnt(sat_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { logic [11:0] e; logic s; int due; } item_t;
  item_t       q[$];
  item_t       it;
  int          checks = 0, failures = 0, advn = 0;
  logic [15:0] sat_exp = '0;
  logic        use_lit = 1'b0, lit_s = 1'b0, ev;
  logic [11:0] lit_e = '0;
  logic [12:0] mv;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  // e^x from plain real arithmetic: e^k and e^(f/16) each rounded to Q.8, product rounded back
  function automatic logic [12:0] model(input logic [7:0] x);
    int     k  = int'($signed(x[7:4]));
    int     f  = int'(x[3:0]);
    real    ei = $exp(real'(k)) * 256.0;
    longint iv, fv, r;
    iv = (ei >= 4095.0) ? 64'sd4095 : longint'($rtoi(ei + 0.5));
    fv = longint'($rtoi($exp(real'(f) / 16.0) * 256.0 + 0.5));
    r  = (iv * fv + 128) >>> 8;
    if (ei >= 4095.0 || r > 4095) return {1'b1, 12'd4095};
    return {1'b0, 12'(r)};
  endfunction
  // Each accepted sample becomes visible once three advancing cycles have elapsed
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      advn    = 0;
      sat_exp = '0;
    end else begin
      ev = q.size() > 0 && q[0].due <= advn;
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      chk("sat_cnt", sat_cnt, sat_exp);
      if (ev) begin
        chk("out_exp", out_exp, q[0].e);
        chk("out_sat", out_sat, q[0].s);
        if (out_ready) begin
`ifdef EXP_SCALE_STATS_EN
          if (q[0].s && sat_exp != 16'hFFFF) sat_exp = sat_exp + 16'd1;
`endif
          void'(q.pop_front());
        end
      end
      if (in_valid && (!ev || out_ready)) begin
        mv = model(in_x);
        if (use_lit) begin
          chk("model_pin", mv, {lit_s, lit_e});
          {it.s, it.e} = {lit_s, lit_e};
        end else {it.s, it.e} = mv;
        it.due = advn + 3;
        q.push_back(it);
      end
      if (!ev || out_ready) advn++;
    end
  end
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input logic [7:0] x, input logic l, input logic [11:0] e, input logic s);
    logic acc;
    int   n = 0;
    in_valid = 1'b1; in_x = x; use_lit = l; lit_e = e; lit_s = s;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0; use_lit = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    idle(2);
    send(8'h00, 1, 12'd256, 0);
    send(8'h10, 1, 12'd696, 0);
    send(8'h20, 1, 12'd1892, 0);
    idle(5);
    send(8'h18, 1, 12'd1147, 0);
    send(8'hF8, 1, 12'd155, 0);
    send(8'hF0, 1, 12'd94, 0);
    send(8'h30, 1, 12'd4095, 1);
    send(8'h7F, 1, 12'd4095, 1);
    send(8'h80, 1, 12'd0, 0);
    idle(6);
`ifdef EXP_SCALE_STATS_EN
    chk("sat_cnt_directed", sat_cnt, 2);
`else
    chk("sat_cnt_directed", sat_cnt, 0);
`endif
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'($urandom), 0, '0, 0);
      end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        if (!out_valid) chk("bp_wait_timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("bp_drained", q.size(), 0);
    send(8'h12, 0, '0, 0);
    idle(1);
    send(8'hE7, 0, '0, 0);
    idle(6);
    send(8'h05, 0, '0, 0);
    send(8'h21, 0, '0, 0);
    send(8'hFF, 0, '0, 0);
    chk("pre_reset_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_exp", out_exp, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    send(8'h1C, 0, '0, 0);
    idle(6);
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(10);
    chk("final_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
